dmem_responder: RTL

Data-memory responder at the far end of the load/store control interface. It accepts one read or write request per transaction, qualified by the decoded `mem_rd_en`/`mem_wr_en` and the access-type codes. It performs little-endian byte, half-word or word access to an internal word array. After a fixed, parameterised latency it returns sign- or zero-extended load data with a one-cycle response strobe. It sits between the execute stage and the writeback mux (result source 2).

---
 rtl/dmem_responder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one load/store, waits a fixed latency, then commits
// the store or returns extended load data with a one-cycle response strobe.
module dmem_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_rd_en,
  input  logic        mem_wr_en,
  input  logic [2:0]  mem_rd_type,
  input  logic [1:0]  mem_wr_type,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        resp_valid,
  output logic        resp_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam int unsigned AW = DEPTH_LOG2 + 2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rd_en_q, rd_en_d;
  logic          wr_en_q, wr_en_d;
  logic [2:0]    rd_type_q, rd_type_d;
  logic [1:0]    wr_type_q, wr_type_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          resp_err_q, resp_err_d;

  logic [31:0]   mem_q [1<<DEPTH_LOG2];

  logic                  accept, commit, acc_err, mem_we;
  logic [DEPTH_LOG2-1:0] widx;
  logic [1:0]            lane;
  logic [31:0]           word, load_val, merged;
  logic [7:0]            sel_byte;
  logic [15:0]           sel_half;

  assign widx     = addr_q[AW-1:2];
  assign lane     = addr_q[1:0];
  assign word     = mem_q[widx];
  assign sel_byte = word[{lane, 3'b000} +: 8];
  assign sel_half = addr_q[1] ? word[31:16] : word[15:0];

  assign accept = (state_q == ST_IDLE) && req_valid && (mem_rd_en || mem_wr_en);
  assign commit = (state_q == ST_WAIT) && (cnt_q == 4'd0);

  // A request with both enables set is a single errored transaction.
  always_comb begin
    acc_err = 1'b0;
    if (rd_en_q && wr_en_q) begin
      acc_err = 1'b1;
    end else if (rd_en_q) begin
      case (rd_type_q)
        3'd0, 3'd4: acc_err = 1'b0;
        3'd1, 3'd5: acc_err = addr_q[0];
        3'd2:       acc_err = (lane != 2'd0);
        default:    acc_err = 1'b1;
      endcase
    end else if (wr_en_q) begin
      case (wr_type_q)
        2'd0:    acc_err = 1'b0;
        2'd1:    acc_err = addr_q[0];
        2'd2:    acc_err = (lane != 2'd0);
        default: acc_err = 1'b1;
      endcase
    end
  end

  always_comb begin
    load_val = '0;
    case (rd_type_q)
      3'd0:    load_val = {{24{sel_byte[7]}}, sel_byte};
      3'd1:    load_val = {{16{sel_half[15]}}, sel_half};
      3'd2:    load_val = word;
      3'd4:    load_val = {24'd0, sel_byte};
      3'd5:    load_val = {16'd0, sel_half};
      default: load_val = '0;
    endcase
  end

  always_comb begin
    merged = word;
    case (wr_type_q)
      2'd0:    merged[{lane, 3'b000} +: 8] = wdata_q[7:0];
      2'd1:    merged[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
      default: merged = wdata_q;
    endcase
  end

  assign mem_we = commit && wr_en_q && !acc_err;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rd_en_d    = rd_en_q;
    wr_en_d    = wr_en_q;
    rd_type_d  = rd_type_q;
    wr_type_d  = wr_type_q;
    rd_data_d  = rd_data_q;
    resp_err_d = resp_err_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d   = ST_WAIT;
          cnt_d     = 4'(LATENCY - 1);
          addr_d    = addr[AW-1:0];
          wdata_d   = wr_data;
          rd_en_d   = mem_rd_en;
          wr_en_d   = mem_wr_en;
          rd_type_d = mem_rd_type;
          wr_type_d = mem_wr_type;
        end
      end
      ST_WAIT: begin
        if (commit) begin
          state_d    = ST_RESP;
          resp_err_d = acc_err;
          if (rd_en_q) rd_data_d = acc_err ? '0 : load_val;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_en_q    <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_type_q  <= '0;
      wr_type_q  <= '0;
      rd_data_q  <= '0;
      resp_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_en_q    <= rd_en_d;
      wr_en_q    <= wr_en_d;
      rd_type_q  <= rd_type_d;
      wr_type_q  <= wr_type_d;
      rd_data_q  <= rd_data_d;
      resp_err_q <= resp_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[widx] <= merged;
  end

  assign req_ready  = rst_n && (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_err   = resp_err_q;
  assign rd_data    = rd_data_q;

endmodule
